// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that shares one registered logic unit between two requesters.
// Each operation goes IDLE -> ISSUE -> CAPTURE -> RESPOND; the unit is enabled only during ISSUE.
module logic_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_fun,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_fun,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             lu_enable,
    output logic [1:0]       lu_fun,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    input  logic [WIDTH-1:0] lu_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t           state_reg;
    logic             last_reg;
    logic             owner_reg;
    logic             lu_enable_reg;
    logic [1:0]       fun_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       rsp_valid_reg;
    logic [WIDTH-1:0] rsp_data_reg [2];

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_ready;
    logic [1:0]       grant;
    logic [1:0]       req_fun [2];
    logic [WIDTH-1:0] req_a [2];
    logic [WIDTH-1:0] req_b [2];
    logic             accept;
    logic             sel;

    assign req_valid  = {req1_valid, req0_valid};
    assign rsp_ready  = {rsp1_ready, rsp0_ready};
    assign req_fun[0] = req0_fun;
    assign req_fun[1] = req1_fun;
    assign req_a[0]   = req0_a;
    assign req_a[1]   = req1_a;
    assign req_b[0]   = req0_b;
    assign req_b[1]   = req1_b;

    // A requester wins if it is alone, or on a tie if it was not the one served last.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grant
            localparam logic ME = 1'(gi);
            assign grant[gi]     = req_valid[gi] & (~req_valid[1-gi] | (last_reg != ME));
            assign req_ready[gi] = (state_reg == IDLE) & grant[gi];
        end
    endgenerate

    assign accept = |req_ready;
    assign sel    = req_ready[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg       <= IDLE;
            last_reg        <= 1'b1;
            owner_reg       <= 1'b0;
            lu_enable_reg   <= 1'b0;
            fun_reg         <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            rsp_valid_reg   <= '0;
            rsp_data_reg[0] <= '0;
            rsp_data_reg[1] <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        fun_reg       <= req_fun[sel];
                        a_reg         <= req_a[sel];
                        b_reg         <= req_b[sel];
                        owner_reg     <= sel;
                        lu_enable_reg <= 1'b1;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE: begin
                    lu_enable_reg <= 1'b0;
                    state_reg     <= CAPTURE;
                end
                CAPTURE: begin
                    // lu_out was registered by the unit on the ISSUE edge
                    rsp_data_reg[owner_reg]  <= lu_out;
                    rsp_valid_reg[owner_reg] <= 1'b1;
                    last_reg                 <= owner_reg;
                    state_reg                <= RESPOND;
                end
                RESPOND: begin
                    if (rsp_ready[owner_reg]) begin
                        rsp_valid_reg <= '0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp0_data  = rsp_data_reg[0];
    assign rsp1_data  = rsp_data_reg[1];
    assign lu_enable  = lu_enable_reg;
    assign lu_fun     = fun_reg;
    assign lu_a       = a_reg;
    assign lu_b       = b_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a behavioural registered logic unit on the lu_* port.
`timescale 1ns/1ps
module tb_logic_unit_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req0_valid = 0, req1_valid = 0;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_fun = 0, req1_fun = 0;
    logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1, rsp1_ready = 1;
    logic [7:0] rsp0_data, rsp1_data;
    logic       lu_enable;
    logic [1:0] lu_fun;
    logic [7:0] lu_a, lu_b;
    logic [7:0] lu_out = 8'h00;
    logic       busy;

    int total = 0;
    int bad = 0;
    int en_count = 0;
    int acc_count = 0;
    bit mon_en = 0;

    logic_unit_arbiter #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .lu_enable(lu_enable), .lu_fun(lu_fun), .lu_a(lu_a), .lu_b(lu_b),
        .lu_out(lu_out), .busy(busy)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] lu_model(input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    // External registered logic unit
    always @(posedge CLK) if (lu_enable) lu_out <= lu_model(lu_fun, lu_a, lu_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Operand-hold monitor: lu_* may only change on an accept edge, to the accepted operands
    always @(posedge CLK) begin
        logic        acc;
        logic [17:0] prev_op, exp_op;
        acc     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        prev_op = {lu_fun, lu_a, lu_b};
        exp_op  = req1_ready ? {req1_fun, req1_a, req1_b} : {req0_fun, req0_a, req0_b};
        if (mon_en && lu_enable) en_count++;
        if (mon_en && acc) acc_count++;
        #3;
        if (mon_en) begin
            if (acc) check("lu_op_on_accept", {14'd0, lu_fun, lu_a, lu_b}, {14'd0, exp_op});
            else     check("lu_op_hold", {14'd0, lu_fun, lu_a, lu_b}, {14'd0, prev_op});
        end
    end

    typedef struct {
        bit         r;
        logic [1:0] fun;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic set_req(input bit r, input logic [1:0] f, input logic [7:0] a, input logic [7:0] b);
        if (r) begin req1_valid = 1; req1_fun = f; req1_a = a; req1_b = b; end
        else   begin req0_valid = 1; req0_fun = f; req0_a = a; req0_b = b; end
    endtask

    // Accept at the next edge, then walk the fixed 4-cycle sequence checking every step.
    task automatic run_op(input bit r, input logic [1:0] f, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp, input bit full);
        int cyc;
        set_req(r, f, a, b);
        #1;
        cyc = 0;
        while (!(r ? req1_ready : req0_ready) && cyc < 20) begin tick(); cyc++; end
        check("ready_seen", {31'd0, r ? req1_ready : req0_ready}, 32'd1);
        tick();                               // t0 accept
        req0_valid = 0; req1_valid = 0;
        if (full) begin
            check("issue_en", {31'd0, lu_enable}, 32'd1);
            check("issue_busy", {31'd0, busy}, 32'd1);
        end
        tick();                               // t1
        if (full) check("capture_en", {31'd0, lu_enable}, 32'd0);
        tick();                               // t2
        check("rsp_valid", {31'd0, r ? rsp1_valid : rsp0_valid}, 32'd1);
        check("rsp_data", {24'd0, r ? rsp1_data : rsp0_data}, {24'd0, exp});
        if (full) check("other_rsp_valid", {31'd0, r ? rsp0_valid : rsp1_valid}, 32'd0);
        tick();                               // t3 handshake
        if (full) check("back_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{0, 2'b10, 8'hF0, 8'h3C, 8'hCF};
        vecs[1] = '{1, 2'b11, 8'h00, 8'h0F, 8'hF0};
        vecs[2] = '{0, 2'b00, 8'hAA, 8'h0F, 8'h0A};
        vecs[3] = '{1, 2'b01, 8'hA0, 8'h05, 8'hA5};
        vecs[4] = '{0, 2'b01, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{1, 2'b00, 8'hFF, 8'hFF, 8'hFF};
        vecs[6] = '{0, 2'b11, 8'hFF, 8'h00, 8'h00};
        vecs[7] = '{1, 2'b10, 8'h55, 8'hAA, 8'hFF};
        vecs[8] = '{0, 2'b00, 8'h3C, 8'h0F, 8'h0C};
        vecs[9] = '{1, 2'b01, 8'h12, 8'h34, 8'h36};

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_lu_en", {31'd0, lu_enable}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        RST = 0;
        tick();

        // Reset asserted mid-ISSUE discards the operation
        set_req(0, 2'b10, 8'hF0, 8'h3C);
        #1;
        check("pre_rst_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 0;
        check("mid_issue_en", {31'd0, lu_enable}, 32'd1);
        #2 RST = 1;
        #1;
        check("async_rst_en", {31'd0, lu_enable}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_lu_a", {24'd0, lu_a}, 32'd0);
        check("async_rst_lu_b", {24'd0, lu_b}, 32'd0);
        check("async_rst_lu_fun", {30'd0, lu_fun}, 32'd0);
        tick();
        RST = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_rsp_after_rst", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end

        // Table-driven single operations
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].r, vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].exp, 1);
            $display("op %0d: req%0d fun=%0d a=%02h b=%02h exp=%02h", i, vecs[i].r,
                     vecs[i].fun, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Round-robin with both requesters held valid; req1 was served last
        set_req(0, 2'b00, 8'hAA, 8'h0F);
        set_req(1, 2'b01, 8'hA0, 8'h05);
        for (int k = 0; k < 4; k++) begin
            int  cyc;
            bit  g;
            #1;
            cyc = 0;
            while (!(req0_ready || req1_ready) && cyc < 20) begin tick(); cyc++; end
            check("rr_ready_both", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
            g = req1_ready;
            tick(); tick(); tick();
            check("rr_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, (k % 2 == 0) ? 32'd1 : 32'd2);
            check("rr_rsp_data", {24'd0, g ? rsp1_data : rsp0_data}, (k % 2 == 0) ? 32'h0A : 32'hA5);
            $display("rr %0d: granted req%0d", k, g);
            tick();
        end
        req0_valid = 0; req1_valid = 0;
        tick();

        // Response backpressure on req1 while req0 waits
        rsp1_ready = 0;
        set_req(1, 2'b11, 8'h00, 8'h0F);
        #1;
        check("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 0;
        set_req(0, 2'b00, 8'hAA, 8'h0F);
        tick(); tick();
        check("bp_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_rsp1_data", {24'd0, rsp1_data}, 32'hF0);
            check("bp_hold", {29'd0, rsp1_valid, busy, req0_ready}, 32'd6);
        end
        rsp1_ready = 1;
        #1;
        check("bp_no_accept_on_hs", {31'd0, req0_ready}, 32'd0);
        tick();
        check("bp_rsp1_done", {31'd0, rsp1_valid}, 32'd0);
        check("bp_req0_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 0;
        tick(); tick();
        check("bp_rsp0_data", {24'd0, rsp0_data}, 32'h0A);
        tick();
        $display("backpressure sequence done");

        // Random ops with the operand-hold monitor active
        mon_en = 1;
        for (int k = 0; k < 20; k++) begin
            bit         r;
            logic [1:0] f;
            logic [7:0] a, b;
            r = 1'($urandom_range(0, 1));
            f = 2'($urandom_range(0, 3));
            a = 8'($urandom);
            b = 8'($urandom);
            run_op(r, f, a, b, lu_model(f, a, b), 0);
            $display("rand %0d: req%0d fun=%0d a=%02h b=%02h", k, r, f, a, b);
        end
        tick(); tick();
        mon_en = 0;
        check("en_count_vs_accepts", en_count, acc_count);
        check("accepts", acc_count, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Two-requester arbiter and sequencer that shares a single registered logic unit (AND/OR/NAND/NOR, 2-bit function code, one-cycle registered result) between two independent clients. It accepts one operation at a time through a valid/ready handshake, using round-robin fairness. It then drives the unit's enable, function and operands for exactly one cycle, captures the registered result, and returns it to the originating requester through a valid/ready response channel. It sits between the system controller's operation sources and the logic unit, and keeps the unit's enable low whenever no operation is in flight, to save power.

## Interface
- WIDTH, 8, operand and result width; must equal the logic unit's operand/result widths

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  requester N presents an operation
- req0_ready / req1_ready  out  1  arbiter accepts requester N's operation this cycle
- req0_fun / req1_fun  in  2  function code: 00 AND, 01 OR, 10 NAND, 11 NOR
- req0_a / req1_a, req0_b / req1_b  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  result for requester N available
- rsp0_ready / rsp1_ready  in  1  requester N takes the result
- rsp0_data / rsp1_data  out  WIDTH  result
- lu_enable  out  1  logic-unit enable
- lu_fun  out  2  logic-unit function
- lu_a, lu_b  out  WIDTH  logic-unit operands
- lu_out  in  WIDTH  registered logic-unit result
- busy  out  1  high in any state other than IDLE

## Operation
- The FSM has four states: IDLE, ISSUE, CAPTURE and RESPOND.
- **IDLE**
  - Grant selection:
    - If only one reqN_valid is high, that requester is granted.
    - If both are high, the requester not served last is granted.
    - `last` resets to 1, so req0 wins the first tie.
  - reqN_ready = (state==IDLE) & grantN. It is combinational and is never high for both requesters.
  - On accept (valid & ready):
    - Latch fun, a and b into operand registers.
    - Record the owner.
    - Go to ISSUE.
- **ISSUE**, one cycle:
  - lu_enable=1.
  - lu_fun, lu_a and lu_b are driven from the operand registers.
  - Next state is CAPTURE.
- **CAPTURE**, one cycle:
  - lu_enable=0.
  - lu_out now holds the result of the ISSUE edge; register it into the owner's result register.
  - Set last=owner.
  - Next state is RESPOND.
- **RESPOND**:
  - rsp<owner>_valid=1 and rsp<owner>_data=result.
  - Hold until rsp<owner>_ready=1, then go to IDLE. The handshake edge completes the transfer.
  - The other requester's rsp_valid stays 0.
- lu_fun, lu_a and lu_b hold the operand registers at all times. They do not toggle outside an accept, which is required for low power.
- rspN_data holds its last value when not valid.
- The arbiter does not use the unit's flag output.
- A requester may deassert valid before it is accepted. Nothing is latched in that case.
- Requests that arrive during busy wait in place. Their ready stays 0.

## Timing
- Reset (asynchronous, any state, mid-operation included):
  - Forces IDLE and clears all registers.
  - Outputs: req*_ready follows the IDLE grant (0 while no valid); rsp*_valid=0, rsp*_data=0, lu_enable=0, lu_fun=0, lu_a=0, lu_b=0, busy=0, last=1.
  - An in-flight operation is discarded and no response is produced.
- Latency: with the accept at edge t0:
  - ISSUE occupies cycle t0→t1.
  - CAPTURE occupies t1→t2.
  - rspN_valid is high from t2.
  - With rsp_ready held high, the transfer completes at edge t3.
  - The next accept can happen no earlier than edge t4, in the IDLE cycle t3→t4.
- Throughput is one operation per 4 cycles minimum.
- Response backpressure: RESPOND holds for any number of cycles, and data stays stable while valid & !ready.
- Simultaneous events:
  - When both requests arrive in the same IDLE cycle, round-robin decides.
  - A new request asserted in the same cycle as the response handshake is not accepted until the next IDLE cycle.
- lu_enable is high for exactly one cycle per accepted operation and is never high in IDLE, CAPTURE or RESPOND.

## Test plan
- **Reset values:** assert RST mid-ISSUE, with req0 A=8'hF0, B=8'h3C.
  - Outputs return immediately to reset values.
  - No rsp0_valid follows.
  - After release, a new op proceeds normally.
- **Single op:** req0 NAND, A=8'hF0, B=8'h3C, with rsp0_ready=1.
  - lu_enable pulses once, at cycle t0→t1.
  - rsp0_valid is high at t2 with rsp0_data=8'hCF.
  - rsp1_valid stays 0.
- **Round-robin:** hold req0 (AND 8'hAA, 8'h0F) and req1 (OR 8'hA0, 8'h05) continuously.
  - Grants are req0, req1, req0, req1.
  - Results alternate between 8'h0A and 8'hA5 on the correct channels.
- **Response backpressure:** hold rsp1_ready=0 for 10 cycles after rsp1_valid is high (NOR 8'h00, 8'h0F).
  - rsp1_data stays stable at 8'hF0.
  - busy=1 throughout.
  - req0 is not accepted until after the handshake.
- **Operand hold:** with a random sequence of 20 ops across all four functions, compare against a model.
  - lu_a, lu_b and lu_fun change only on accept edges.
  - lu_enable count equals the number of accepts.
